// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32 opcode constants, NOP encoding and the predecode record.
package riscv_pkg;

    localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
    localparam logic [6:0]  OPC_JAL    = 7'b1101111;
    localparam logic [6:0]  OPC_JALR   = 7'b1100111;
    localparam logic [31:0] RV_NOP     = 32'h0000_0013;

    typedef struct packed {
        logic       is_branch;
        logic       is_jal;
        logic       is_jalr;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } predecode_t;

endpackage

// File: rtl/if_id_predecode.sv
// if_id_predecode: combinational control-flow and register-field extraction for one fetched word.
module if_id_predecode
    import riscv_pkg::*;
(
    input  logic [31:0] instr,
    input  logic        err,
    output predecode_t  pd
);

    logic [6:0] opc;
    logic       unused_bits;

    assign opc         = instr[6:0];
    assign unused_bits = ^{instr[31:25], instr[14:12]};

    // A faulting fetch carries no real instruction, so it decodes to nothing.
    assign pd = err ? '0 : predecode_t'{opc == OPC_BRANCH, opc == OPC_JAL, opc == OPC_JALR,
                                        instr[11:7], instr[19:15], instr[24:20]};

endmodule

// File: rtl/if_id_queue.sv
// if_id_queue: FIFO between fetch and decode with flush; IF_ID_PREDECODE_EN adds stored predecode outputs.
module if_id_queue
    import riscv_pkg::*;
#(
    parameter int          DEPTH     = 2,
    parameter logic [31:0] NOP_INSTR = RV_NOP
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_IF,
    input  logic [31:0] pc_IF,
    input  logic [31:0] pcPlus4_IF,
    input  logic [31:0] instr_IF,
    input  logic        err_IF,
    output logic        ready_IF,
    input  logic        flush,
    input  logic        ready_ID,
    output logic        valid_ID,
    output logic [31:0] pc_ID,
    output logic [31:0] pcPlus4_ID,
    output logic [31:0] instr_ID,
`ifdef IF_ID_PREDECODE_EN
    output logic        is_branch_ID,
    output logic        is_jal_ID,
    output logic        is_jalr_ID,
    output logic [4:0]  rd_ID,
    output logic [4:0]  rs1_ID,
    output logic [4:0]  rs2_ID,
`endif
    output logic        err_ID
);

    localparam int         AW   = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   count;
    logic          push, pop;
    logic [31:0]   pc_q    [DEPTH];
    logic [31:0]   pc4_q   [DEPTH];
    logic [31:0]   instr_q [DEPTH];
    logic          err_q   [DEPTH];

    // Handshakes look only at registered count, keeping ready/valid free of input paths.
    assign ready_IF = count < FULL;
    assign valid_ID = count != '0;
    assign push     = valid_IF && ready_IF && !flush;
    assign pop      = valid_ID && ready_ID && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (flush) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            count  <= count + (AW + 1)'(push) - (AW + 1)'(pop);
            rd_ptr <= rd_ptr + AW'(pop);
            wr_ptr <= wr_ptr + AW'(push);
        end
    end

`ifdef IF_ID_PREDECODE_EN
    predecode_t pd_in;
    predecode_t pd_q [DEPTH];
    predecode_t pd_out;

    if_id_predecode u_predecode (
        .instr (instr_IF),
        .err   (err_IF),
        .pd    (pd_in)
    );

    assign pd_out       = valid_ID ? pd_q[rd_ptr] : '0;
    assign is_branch_ID = pd_out.is_branch;
    assign is_jal_ID    = pd_out.is_jal;
    assign is_jalr_ID   = pd_out.is_jalr;
    assign rd_ID        = pd_out.rd;
    assign rs1_ID       = pd_out.rs1;
    assign rs2_ID       = pd_out.rs2;
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            pc_q[wr_ptr]    <= pc_IF;
            pc4_q[wr_ptr]   <= pcPlus4_IF;
            instr_q[wr_ptr] <= instr_IF;
            err_q[wr_ptr]   <= err_IF;
`ifdef IF_ID_PREDECODE_EN
            pd_q[wr_ptr]    <= pd_in;
`endif
        end
    end

    assign pc_ID      = valid_ID ? pc_q[rd_ptr] : '0;
    assign pcPlus4_ID = valid_ID ? pc4_q[rd_ptr] : '0;
    assign err_ID     = valid_ID && err_q[rd_ptr];
    assign instr_ID   = (valid_ID && !err_q[rd_ptr]) ? instr_q[rd_ptr] : NOP_INSTR;

endmodule

// File: tb/tb_if_id_queue.sv
// tb_if_id_queue: directed self-checking bench for if_id_queue (IF_ID_PREDECODE_EN optional).
module tb_if_id_queue;

    logic        clk, rst, valid_IF, err_IF, flush, ready_ID;
    logic [31:0] pc_IF, pcPlus4_IF, instr_IF;
    logic        ready_IF, valid_ID, err_ID;
    logic [31:0] pc_ID, pcPlus4_ID, instr_ID;
`ifdef IF_ID_PREDECODE_EN
    logic        is_branch_ID, is_jal_ID, is_jalr_ID;
    logic [4:0]  rd_ID, rs1_ID, rs2_ID;
`endif
    int vecs = 0;
    int miscompares = 0;

    if_id_queue dut (
        .clk        (clk),
        .rst        (rst),
        .valid_IF   (valid_IF),
        .pc_IF      (pc_IF),
        .pcPlus4_IF (pcPlus4_IF),
        .instr_IF   (instr_IF),
        .err_IF     (err_IF),
        .ready_IF   (ready_IF),
        .flush      (flush),
        .ready_ID   (ready_ID),
        .valid_ID   (valid_ID),
        .pc_ID      (pc_ID),
        .pcPlus4_ID (pcPlus4_ID),
        .instr_ID   (instr_ID),
`ifdef IF_ID_PREDECODE_EN
        .is_branch_ID (is_branch_ID),
        .is_jal_ID    (is_jal_ID),
        .is_jalr_ID   (is_jalr_ID),
        .rd_ID        (rd_ID),
        .rs1_ID       (rs1_ID),
        .rs2_ID       (rs2_ID),
`endif
        .err_ID     (err_ID)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins, input logic e);
        valid_IF   = v;
        pc_IF      = pc;
        pcPlus4_IF = pc + 32'd4;
        instr_IF   = ins;
        err_IF     = e;
    endtask

    task automatic test_reset;
        #2;
        vecs++;
        if ({valid_ID, ready_IF, err_ID, pc_ID, pcPlus4_ID, instr_ID} !== {1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h13}) begin
            miscompares++;
            $display("FAIL reset_state got v=%b r=%b e=%b pc=%h pc4=%h ins=%h exp v=0 r=1 e=0 pc=0 pc4=0 ins=00000013",
                     valid_ID, ready_IF, err_ID, pc_ID, pcPlus4_ID, instr_ID);
        end
        step;
        rst = 0;
    endtask

    task automatic test_single;
        ready_ID = 1;
        drive(1, 32'h0, 32'h00500093, 0);
        step;
        drive(0, 32'h0, 32'h0, 0);
        vecs++;
        if ({valid_ID, pc_ID, pcPlus4_ID, instr_ID} !== {1'b1, 32'h0, 32'h4, 32'h00500093}) begin
            miscompares++;
            $display("FAIL single_push got v=%b pc=%h pc4=%h ins=%h exp v=1 pc=0 pc4=4 ins=00500093",
                     valid_ID, pc_ID, pcPlus4_ID, instr_ID);
        end
        step;
        vecs++;
        if (valid_ID !== 1'b0) begin
            miscompares++;
            $display("FAIL single_pop got v=%b exp 0", valid_ID);
        end
    endtask

    task automatic test_fill;
        ready_ID = 0;
        drive(1, 32'h0, 32'h00100093, 0);
        step;
        drive(1, 32'h4, 32'h00200093, 0);
        step;
        vecs++;
        if ({ready_IF, pc_ID} !== {1'b0, 32'h0}) begin
            miscompares++;
            $display("FAIL fill_full got r=%b pc=%h exp r=0 pc=0", ready_IF, pc_ID);
        end
        drive(1, 32'h8, 32'h00300093, 0);
        step;
        vecs++;
        if ({ready_IF, pc_ID, instr_ID} !== {1'b0, 32'h0, 32'h00100093}) begin
            miscompares++;
            $display("FAIL fill_hold got r=%b pc=%h ins=%h exp r=0 pc=0 ins=00100093", ready_IF, pc_ID, instr_ID);
        end
        ready_ID = 1;
        step;
        vecs++;
        if ({valid_ID, ready_IF, pc_ID} !== {1'b1, 1'b1, 32'h4}) begin
            miscompares++;
            $display("FAIL fill_pop1 got v=%b r=%b pc=%h exp v=1 r=1 pc=4", valid_ID, ready_IF, pc_ID);
        end
        step;
        drive(0, 32'h0, 32'h0, 0);
        vecs++;
        if ({valid_ID, pc_ID, instr_ID} !== {1'b1, 32'h8, 32'h00300093}) begin
            miscompares++;
            $display("FAIL fill_pop2 got v=%b pc=%h ins=%h exp v=1 pc=8 ins=00300093", valid_ID, pc_ID, instr_ID);
        end
        step;
        vecs++;
        if (valid_ID !== 1'b0) begin
            miscompares++;
            $display("FAIL fill_drain got v=%b exp 0", valid_ID);
        end
    endtask

    task automatic test_flush;
        ready_ID = 0;
        drive(1, 32'h10, 32'h00a00093, 0);
        step;
        drive(1, 32'h14, 32'h00b00093, 0);
        step;
        flush = 1;
        drive(1, 32'h40, 32'h00c00093, 0);
        step;
        flush = 0;
        drive(0, 32'h0, 32'h0, 0);
        vecs++;
        if ({valid_ID, ready_IF, pc_ID, instr_ID} !== {1'b0, 1'b1, 32'h0, 32'h13}) begin
            miscompares++;
            $display("FAIL flush_empty got v=%b r=%b pc=%h ins=%h exp v=0 r=1 pc=0 ins=00000013",
                     valid_ID, ready_IF, pc_ID, instr_ID);
        end
        ready_ID = 1;
        step;
        vecs++;
        if (valid_ID !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_drop got v=%b pc=%h exp v=0", valid_ID, pc_ID);
        end
        drive(1, 32'h50, 32'h00d00093, 0);
        step;
        drive(0, 32'h0, 32'h0, 0);
        vecs++;
        if ({valid_ID, pc_ID} !== {1'b1, 32'h50}) begin
            miscompares++;
            $display("FAIL flush_resume got v=%b pc=%h exp v=1 pc=50", valid_ID, pc_ID);
        end
        step;
    endtask

    task automatic test_err;
        ready_ID = 0;
        drive(1, 32'h2, 32'h00500093, 1);
        step;
        drive(0, 32'h0, 32'h0, 0);
        vecs++;
        if ({valid_ID, err_ID, pc_ID, pcPlus4_ID, instr_ID} !== {1'b1, 1'b1, 32'h2, 32'h6, 32'h13}) begin
            miscompares++;
            $display("FAIL err_entry got v=%b e=%b pc=%h pc4=%h ins=%h exp v=1 e=1 pc=2 pc4=6 ins=00000013",
                     valid_ID, err_ID, pc_ID, pcPlus4_ID, instr_ID);
        end
        ready_ID = 1;
        step;
        vecs++;
        if ({valid_ID, err_ID} !== 2'b00) begin
            miscompares++;
            $display("FAIL err_pop got v=%b e=%b exp v=0 e=0", valid_ID, err_ID);
        end
    endtask

    task automatic test_back_to_back;
        ready_ID = 1;
        drive(1, 32'h100, 32'h00000093, 0);
        step;
        for (int i = 0; i < 10; i++) begin
            drive(1, 32'h100 + 32'(4 * (i + 1)), 32'h00000093, 0);
            vecs++;
            if ({valid_ID, ready_IF, pc_ID} !== {1'b1, 1'b1, 32'h100 + 32'(4 * i)}) begin
                miscompares++;
                $display("FAIL b2b_%0d got v=%b r=%b pc=%h exp v=1 r=1 pc=%h",
                         i, valid_ID, ready_IF, pc_ID, 32'h100 + 32'(4 * i));
            end
            step;
        end
        drive(0, 32'h0, 32'h0, 0);
        vecs++;
        if ({valid_ID, pc_ID} !== {1'b1, 32'h128}) begin
            miscompares++;
            $display("FAIL b2b_last got v=%b pc=%h exp v=1 pc=128", valid_ID, pc_ID);
        end
        step;
        vecs++;
        if (valid_ID !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_drain got v=%b exp 0", valid_ID);
        end
    endtask

    task automatic test_async_reset;
        ready_ID = 0;
        drive(1, 32'h200, 32'h00000093, 0);
        step;
        drive(0, 32'h0, 32'h0, 0);
        #2 rst = 1;
        #1;
        vecs++;
        if ({valid_ID, ready_IF, pc_ID, instr_ID} !== {1'b0, 1'b1, 32'h0, 32'h13}) begin
            miscompares++;
            $display("FAIL async_reset got v=%b r=%b pc=%h ins=%h exp v=0 r=1 pc=0 ins=00000013",
                     valid_ID, ready_IF, pc_ID, instr_ID);
        end
        #1 rst = 0;
        drive(1, 32'h204, 32'h00000093, 0);
        step;
        drive(0, 32'h0, 32'h0, 0);
        vecs++;
        if ({valid_ID, pc_ID} !== {1'b1, 32'h204}) begin
            miscompares++;
            $display("FAIL post_reset_push got v=%b pc=%h exp v=1 pc=204", valid_ID, pc_ID);
        end
        ready_ID = 1;
        step;
    endtask

`ifdef IF_ID_PREDECODE_EN
    task automatic test_predecode;
        ready_ID = 0;
        drive(1, 32'h300, 32'h0000006f, 0);
        step;
        drive(1, 32'h304, 32'h00208463, 0);
        vecs++;
        if ({is_jal_ID, is_branch_ID, is_jalr_ID, rd_ID} !== {1'b1, 1'b0, 1'b0, 5'd0}) begin
            miscompares++;
            $display("FAIL pd_jal got j=%b b=%b jr=%b rd=%0d exp j=1 b=0 jr=0 rd=0", is_jal_ID, is_branch_ID, is_jalr_ID, rd_ID);
        end
        ready_ID = 1;
        step;
        drive(0, 32'h0, 32'h0, 0);
        vecs++;
        if ({is_branch_ID, is_jal_ID, rs1_ID, rs2_ID} !== {1'b1, 1'b0, 5'd1, 5'd2}) begin
            miscompares++;
            $display("FAIL pd_beq got b=%b j=%b rs1=%0d rs2=%0d exp b=1 j=0 rs1=1 rs2=2", is_branch_ID, is_jal_ID, rs1_ID, rs2_ID);
        end
        step;
        vecs++;
        if ({is_branch_ID, rs1_ID, rs2_ID} !== {1'b0, 5'd0, 5'd0}) begin
            miscompares++;
            $display("FAIL pd_empty got b=%b rs1=%0d rs2=%0d exp all 0", is_branch_ID, rs1_ID, rs2_ID);
        end
    endtask
`endif

    initial begin
        rst      = 1;
        flush    = 0;
        ready_ID = 0;
        drive(0, 32'h0, 32'h0, 0);
        test_reset;
        test_single;
        test_fill;
        test_flush;
        test_err;
        test_back_to_back;
        test_async_reset;
`ifdef IF_ID_PREDECODE_EN
        test_predecode;
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end

endmodule

// File: doc/if_id_queue.md
IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 Parameter DEPTH, default 2, number of instruction entries; SHALL be a power of two and at least 2.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0), instruction presented when no valid entry exists.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 valid_IF  input  1  fetch presents an instruction this cycle.
REQ-006 pc_IF / pcPlus4_IF  input  32 each  PC and PC+4 of the fetched instruction.
REQ-007 instr_IF  input  32  fetched instruction word.
REQ-008 err_IF  input  1  fetch fault (misaligned or out-of-range PC).
REQ-009 ready_IF  output  1  queue accepts a push; fetch stall = ~ready_IF.
REQ-010 flush  input  1  redirect (taken branch, jump, interrupt); discards all entries.
REQ-011 ready_ID  input  1  decode consumes the head entry this cycle.
REQ-012 valid_ID  output  1  head entry valid.
REQ-013 pc_ID / pcPlus4_ID / instr_ID  output  32 each  head entry fields.
REQ-014 err_ID  output  1  head entry carries a fetch fault.

Function
REQ-015 Push SHALL occur when valid_IF && ready_IF && !flush; pop SHALL occur when valid_ID && ready_ID && !flush.
REQ-016 ready_IF SHALL be (count < DEPTH), derived from registered state only; no combinational path from ready_ID or valid_IF.
REQ-017 valid_ID SHALL be (count != 0), from registered state only.
REQ-018 Latency: an entry pushed at edge N SHALL appear at the head (valid_ID=1) in cycle N+1 if the queue was empty; no same-cycle bypass.
REQ-019 Order: strict FIFO; read/write pointers SHALL wrap modulo DEPTH; count width $clog2(DEPTH)+1.
REQ-020 Simultaneous push and pop: count unchanged, both pointers advance; when full, push is refused (ready_IF=0) even if a pop occurs.
REQ-021 flush SHALL have priority over push and pop: next cycle count=0, pointers=0, same-cycle push dropped.
REQ-022 Empty: instr_ID=NOP_INSTR, pc_ID=0, pcPlus4_ID=0, err_ID=0.
REQ-023 Entry with err set: err_ID=1, instr_ID=NOP_INSTR, pc_ID the faulting PC.
REQ-024 ready_ID asserted while valid_ID=0 SHALL have no effect.

Reset
REQ-025 On rst: count=0, pointers=0, valid_ID=0, ready_IF=1, outputs per REQ-022, asynchronously and mid-operation alike; entry storage need not be cleared.
REQ-026 First push SHALL be accepted in the first cycle after rst deasserts.

Configuration
REQ-027 Macro IF_ID_PREDECODE_EN defined: each entry stores predecode computed at push: is_branch_ID (opcode 1100011), is_jal_ID (1101111), is_jalr_ID (1100111), rd_ID [11:7], rs1_ID [19:15], rs2_ID [24:20], all zero when empty or err.
REQ-028 Macro undefined: those ports and storage SHALL be absent; all other behaviour identical.

Structure
REQ-029 Shared package riscv_pkg SHALL hold opcode constants, the NOP constant and the predecode struct typedef.
REQ-030 Predecode logic SHALL be one combinational sub-module, if_id_predecode, instantiated only under IF_ID_PREDECODE_EN.

Verification
REQ-031 Reset then push pc_IF=0x0, instr_IF=0x00500093, ready_ID=1 -> next cycle valid_ID=1, pc_ID=0x0, pcPlus4_ID=0x4, instr_ID=0x00500093.
REQ-032 ready_ID=0, push 0x0,0x4,0x8 on consecutive cycles -> ready_IF=0 after second push, 0x8 held by fetch; release -> pops 0x0,0x4,0x8 in order.
REQ-033 Full queue, flush=1 together with valid_IF (pc 0x40) -> next cycle valid_ID=0, instr_ID=0x00000013, ready_IF=1; 0x40 never appears.
REQ-034 Push with err_IF=1, pc_IF=0x2 -> err_ID=1, instr_ID=0x00000013, pc_ID=0x2.
REQ-035 Continuous push+pop for 10 cycles at DEPTH=2 -> pointer wrap, count constant at 1, no lost or duplicated PC.
REQ-036 With IF_ID_PREDECODE_EN, push 0x0000006F (jal x0) -> is_jal_ID=1, rd_ID=0; push 0x00208463 (beq x1,x2) -> is_branch_ID=1, rs1_ID=1, rs2_ID=2.
